// File: rtl/amp_pkg.sv
// amp_pkg: shared FSM states and constants for the LTC6912 SPI write controller
package amp_pkg;
  typedef enum logic [2:0] {IDLE, START, HIGH, LOW, STOP, FINISH} state_e;
  localparam logic [7:0] GAIN_DEFAULT = 8'h11;
  localparam int CNT_W = 16;
endpackage

// File: rtl/amp_clk_div.sv
// amp_clk_div: phase counter; tick_o high on the last of DIV cycles, clr_i restarts the phase
module amp_clk_div
  import amp_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  output logic tick_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign tick_o = cnt_q == CNT_W'(DIV - 1);
  assign cnt_d = (clr_i || tick_o) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/amp.sv
// amp: shifts GAIN_WORD MSB-first to the preamp over SPI mode 0, then pulses DONE_AMP
// ports: clk, reset (sync, active high), GO_AMP start pulse; DONE_AMP, SPI_CLK_AMP,
// SPI_MOSI_AMP, AMP_CS (active low), AMP_SHDN (always 0). Outputs lag the state by one cycle.
module amp
  import amp_pkg::*;
#(
  parameter logic [7:0] GAIN_WORD = GAIN_DEFAULT,
  parameter int         CLK_DIV   = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic GO_AMP,
  output logic DONE_AMP,
  output logic SPI_CLK_AMP,
  output logic SPI_MOSI_AMP,
  output logic AMP_CS,
  output logic AMP_SHDN
);
  state_e state_q, state_d;
  logic [7:0] sh_q, sh_d;
  logic [2:0] bit_q, bit_d;
  logic tick, cs_d, sck_d, mosi_d, done_d;
  amp_clk_div #(.DIV(CLK_DIV)) u_div (
    .clk(clk),
    .reset(reset),
    .clr_i(state_d != state_q),
    .tick_o(tick)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sh_q         <= '0;
      bit_q        <= '0;
      AMP_CS       <= 1'b1;
      SPI_CLK_AMP  <= 1'b0;
      SPI_MOSI_AMP <= 1'b0;
      DONE_AMP     <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      bit_q        <= bit_d;
      AMP_CS       <= cs_d;
      SPI_CLK_AMP  <= sck_d;
      SPI_MOSI_AMP <= mosi_d;
      DONE_AMP     <= done_d;
    end
  end
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    case (state_q)
      IDLE: if (GO_AMP) begin
        state_d = START;
        sh_d    = GAIN_WORD;
        bit_d   = '0;
      end
      START: if (tick) state_d = HIGH;
      HIGH: if (tick) begin
        if (bit_q == 3'd7) state_d = STOP;
        else begin
          state_d = LOW;
          bit_d   = bit_q + 3'd1;
          sh_d    = {sh_q[6:0], 1'b0};
        end
      end
      LOW: if (tick) state_d = HIGH;
      STOP: if (tick) state_d = FINISH;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    cs_d   = !(state_q inside {START, HIGH, LOW, STOP});
    sck_d  = state_q == HIGH;
    mosi_d = cs_d ? 1'b0 : sh_q[7];
    done_d = state_q == FINISH;
  end
  assign AMP_SHDN = 1'b0;
endmodule

// File: tb/tb_amp.sv
// tb_amp: directed stimulus with a bit scoreboard for two amp instances (0x11/div 4, 0xA5/div 1)
module tb_amp;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [1:0] go_v = '0;
  logic [1:0] done_v, sck_v, mosi_v, cs_v, shdn_v;
  int n_checks = 0;
  int n_fail = 0;
  bit q0[$];
  bit q1[$];
  int hi[2] = '{0, 0};
  int lo[2] = '{0, 0};
  int len[2] = '{0, 0};
  int edg[2] = '{0, 0};
  logic [1:0] sck_p = '0, cs_p = '1, done_p = '0;
  bit [1:0] abort = '0;
  int k;
  int seen;

  always #5 clk = ~clk;

  amp dut0 (
    .clk(clk), .reset(reset), .GO_AMP(go_v[0]), .DONE_AMP(done_v[0]),
    .SPI_CLK_AMP(sck_v[0]), .SPI_MOSI_AMP(mosi_v[0]), .AMP_CS(cs_v[0]), .AMP_SHDN(shdn_v[0])
  );
  amp #(.GAIN_WORD(8'hA5), .CLK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .GO_AMP(go_v[1]), .DONE_AMP(done_v[1]),
    .SPI_CLK_AMP(sck_v[1]), .SPI_MOSI_AMP(mosi_v[1]), .AMP_CS(cs_v[1]), .AMP_SHDN(shdn_v[1])
  );

  function automatic int dv(int i);
    return i == 0 ? 4 : 1;
  endfunction
  function automatic int qsize(int i);
    return i == 0 ? q0.size() : q1.size();
  endfunction
  function automatic bit pop(int i);
    return i == 0 ? q0.pop_front() : q1.pop_front();
  endfunction
  function automatic void flush(int i);
    if (i == 0) q0.delete();
    else q1.delete();
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(int i, logic [7:0] w, bit push);
    if (push)
      for (int b = 7; b >= 0; b--) begin
        if (i == 0) q0.push_back(w[b]);
        else q1.push_back(w[b]);
      end
    go_v[i] = 1'b1;
    @(negedge clk);
    go_v[i] = 1'b0;
  endtask

  task automatic wait_done(int i, output int n);
    n = 0;
    while (!done_v[i] && n < 300) begin
      @(negedge clk);
      n++;
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (sck_v[i] && !sck_p[i]) begin
        chk($sformatf("sck_low_%0d", i), lo[i], dv(i));
        chk($sformatf("bit_avail_%0d", i), qsize(i) > 0, 1);
        if (qsize(i) > 0) chk($sformatf("mosi_bit_%0d", i), mosi_v[i], pop(i));
        lo[i] = 0;
        edg[i]++;
      end
      if (!sck_v[i] && sck_p[i]) begin
        if (!abort[i]) chk($sformatf("sck_high_%0d", i), hi[i], dv(i));
        hi[i] = 0;
      end
      if (sck_v[i]) hi[i]++;
      else if (!cs_v[i]) lo[i]++;
      if (!cs_v[i]) len[i]++;
      if (cs_v[i] && !cs_p[i]) begin
        if (abort[i]) begin
          chk($sformatf("abort_no_done_%0d", i), done_v[i], 0);
          flush(i);
          abort[i] = 1'b0;
        end else begin
          chk($sformatf("cs_low_len_%0d", i), len[i], 17 * dv(i));
          chk($sformatf("sck_edges_%0d", i), edg[i], 8);
          chk($sformatf("done_at_cs_rise_%0d", i), done_v[i], 1);
          chk($sformatf("shdn_%0d", i), shdn_v[i], 0);
        end
        len[i] = 0;
        edg[i] = 0;
        lo[i] = 0;
      end
      if (done_v[i]) begin
        chk($sformatf("done_width_%0d", i), done_p[i], 0);
        chk($sformatf("done_cs_was_low_%0d", i), cs_p[i], 0);
      end
      sck_p[i] = sck_v[i];
      cs_p[i] = cs_v[i];
      done_p[i] = done_v[i];
    end
  end

  initial begin
    @(negedge clk);
    chk("reset_state", {cs_v, sck_v, mosi_v, done_v, shdn_v}, {2'b11, 8'b0});
    reset = 1'b0;
    repeat (100) begin
      @(negedge clk);
      chk("idle", {cs_v, sck_v, mosi_v, done_v, shdn_v}, {2'b11, 8'b0});
    end
    pulse(0, 8'h11, 1);
    wait_done(0, k);
    chk("latency_11", k, 69);
    repeat (3) @(negedge clk);
    pulse(1, 8'hA5, 1);
    wait_done(1, k);
    chk("latency_a5", k, 18);
    repeat (3) @(negedge clk);
    pulse(0, 8'h11, 1);
    repeat (28) @(negedge clk);
    pulse(0, 8'h11, 0);
    wait_done(0, k);
    chk("busy_latency", k, 40);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      seen |= !cs_v[0];
    end
    chk("busy_no_retrigger", seen, 0);
    for (int t = 0; t < 2; t++)
      for (int b = 7; b >= 0; b--) q0.push_back(b == 4 || b == 0);
    go_v[0] = 1'b1;
    wait_done(0, k);
    chk("b2b_first", k, 70);
    @(negedge clk);
    wait_done(0, k);
    chk("b2b_period", k, 69);
    go_v[0] = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      seen |= !cs_v[0];
    end
    chk("b2b_stops", seen, 0);
    pulse(0, 8'h11, 1);
    repeat (37) @(negedge clk);
    abort[0] = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    chk("reset_mid", {cs_v[0], sck_v[0], mosi_v[0], done_v[0]}, 4'b1000);
    reset = 1'b0;
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      seen |= done_v[0];
    end
    chk("reset_mid_no_done", seen, 0);
    pulse(0, 8'h11, 1);
    wait_done(0, k);
    chk("after_reset_latency", k, 69);
    repeat (5) @(negedge clk);
    chk("queues_drained", q0.size() + q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
